// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
//   stage_t : one tracked in-flight instruction {valid, wr_en, is_load, addr}
//   FWD_RF  : select value meaning "take the operand from the register file"
//   fwd_w   : width of a forward select for a given tracking depth
package pipe_pkg;
  // Addresses are stored zero-extended to this width; REG_AW must not exceed it.
  localparam int STG_AW = 8;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic              is_load;
    logic [STG_AW-1:0] addr;
  } stage_t;

  function automatic int fwd_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/hazard_fwd_match.sv
// Per-source priority encoder over the tracked stages.
//   stg      : tracked stages, index 1 = EX (youngest)
//   src      : source register address (zero-extended)
//   src_used : source is actually read
//   sel      : smallest matching stage index, FWD_RF when none
//   load_haz : youngest producer is a load whose data is not yet forwardable
module hazard_fwd_match
  import pipe_pkg::*;
#(
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int ZERO_REG  = 1,
  parameter int SEL_W     = 2
) (
  input  stage_t [FWD_DEPTH:1] stg,
  input  logic [STG_AW-1:0]    src,
  input  logic                 src_used,
  output logic [SEL_W-1:0]     sel,
  output logic                 load_haz
);
  always_comb begin
    sel      = SEL_W'(FWD_RF);
    load_haz = 1'b0;
    if (src_used && !(ZERO_REG != 0 && src == '0)) begin
      // Walk oldest to youngest so the youngest match is the one that sticks.
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (stg[k].valid && stg[k].wr_en && stg[k].addr == src) begin
          sel      = SEL_W'(k);
          load_haz = stg[k].is_load && (k <= LOAD_LAT);
        end
      end
    end
  end
endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the five-stage in-order pipeline.
// Tracks destinations past ID in a shadow pipeline, drives forward selects,
// load-use stalls, memory-busy freeze and redirect flushes, and keeps
// saturating stall/flush counters.
//   inputs : id_* (ID-stage instruction), ex_redirect, mem_busy
//   outputs: pc_en, ifid_en, ifid_clr, idex_clr (pipeline register control),
//            fwd_rs_sel/fwd_rt_sel (0 = RF, k = stage k), stall_cnt/flush_cnt
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int ZERO_REG  = 1,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           id_valid,
  input  logic [REG_AW-1:0]              id_rs,
  input  logic [REG_AW-1:0]              id_rt,
  input  logic                           id_rs_used,
  input  logic                           id_rt_used,
  input  logic                           id_wr_en,
  input  logic [REG_AW-1:0]              id_wr_addr,
  input  logic                           id_is_load,
  input  logic                           ex_redirect,
  input  logic                           mem_busy,
  output logic                           pc_en,
  output logic                           ifid_en,
  output logic                           ifid_clr,
  output logic                           idex_clr,
  output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_rs_sel,
  output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_rt_sel,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic [CNT_W-1:0]               flush_cnt
);
  localparam int SEL_W = fwd_w(FWD_DEPTH);

  stage_t [FWD_DEPTH:1]        stg;
  logic   [1:0][STG_AW-1:0]    src;
  logic   [1:0]                used;
  logic   [1:0][SEL_W-1:0]     sel;
  logic   [1:0]                haz;
  logic                        load_use;

  assign src[0]  = STG_AW'(id_rs);
  assign src[1]  = STG_AW'(id_rt);
  assign used[0] = id_rs_used;
  assign used[1] = id_rt_used;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_src
      hazard_fwd_match #(
        .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT),
        .ZERO_REG(ZERO_REG),   .SEL_W(SEL_W)
      ) u_match (
        .stg(stg), .src(src[i]), .src_used(used[i]),
        .sel(sel[i]), .load_haz(haz[i])
      );
    end
  endgenerate

  assign load_use = id_valid && (|haz);

  // Selects stay live during a freeze; only reset forces them to RF.
  assign fwd_rs_sel = rst_n ? sel[0] : SEL_W'(FWD_RF);
  assign fwd_rt_sel = rst_n ? sel[1] : SEL_W'(FWD_RF);

  always_comb begin
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    ifid_clr = 1'b0;
    idex_clr = 1'b0;
    if (!rst_n) begin
      // held at the advance pattern
    end else if (mem_busy) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if (ex_redirect) begin
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (load_use) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      for (int k = FWD_DEPTH; k >= 2; k--) stg[k] <= stg[k-1];
      if (ex_redirect || load_use) begin
        stg[1] <= '0;
      end else begin
        stg[1] <= '{valid: id_valid, wr_en: id_wr_en, is_load: id_is_load,
                    addr: STG_AW'(id_wr_addr)};
      end
      if (ex_redirect) begin
        if (flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
      end else if (load_use) begin
        if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios followed by
// randomized traffic, checked against an in-bench model of in-flight
// instructions. A second instance with 2-bit counters exercises saturation.
module tb_pipe_hazard_unit;
  localparam int D  = 3;
  localparam int LL = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load;
  logic [4:0] id_rs, id_rt, id_wr_addr;
  logic       ex_redirect, mem_busy;

  logic       pc_en, ifid_en, ifid_clr, idex_clr;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [15:0] stall_cnt, flush_cnt;
  logic       s_pc_en, s_ifid_en, s_ifid_clr, s_idex_clr;
  logic [1:0] s_fwd_rs_sel, s_fwd_rt_sel, s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
    .idex_clr(idex_clr), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_unit #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy), .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_clr(s_ifid_clr),
    .idex_clr(s_idex_clr), .fwd_rs_sel(s_fwd_rs_sel), .fwd_rt_sel(s_fwd_rt_sel),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: in-flight instructions by position, 1 = EX.
  int mv[1:D], mw[1:D], ml[1:D], ma[1:D];
  int m_stall, m_flush, m_stall_s, m_flush_s;

  task automatic model_clear();
    for (int k = 1; k <= D; k++) begin
      mv[k] = 0; mw[k] = 0; ml[k] = 0; ma[k] = 0;
    end
    m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
  endtask

  task automatic youngest(input int src, input int used, output int sel, output int lhaz);
    sel = 0; lhaz = 0;
    if (used != 0 && src != 0) begin
      for (int k = 1; k <= D; k++) begin
        if (mv[k] != 0 && mw[k] != 0 && ma[k] == src) begin
          sel = k;
          lhaz = (ml[k] != 0 && k <= LL) ? 1 : 0;
          break;
        end
      end
    end
  endtask

  // One clock: inputs already driven at negedge; check, then step the model.
  task automatic cycle();
    int srs, lrs, srt, lrt, luse, e_pc, e_ifid, e_ifc, e_idc;
    #1;
    if (!rst_n) model_clear();
    youngest(int'(id_rs), int'(id_rs_used), srs, lrs);
    youngest(int'(id_rt), int'(id_rt_used), srt, lrt);
    luse = (id_valid && (lrs != 0 || lrt != 0)) ? 1 : 0;
    e_pc = 1; e_ifid = 1; e_ifc = 0; e_idc = 0;
    if (!rst_n) begin
      srs = 0; srt = 0;
    end else if (mem_busy) begin
      e_pc = 0; e_ifid = 0;
    end else if (ex_redirect) begin
      e_ifc = 1; e_idc = 1;
    end else if (luse != 0) begin
      e_pc = 0; e_ifid = 0; e_idc = 1;
    end
    chk("pc_en",    int'(pc_en),    e_pc);
    chk("ifid_en",  int'(ifid_en),  e_ifid);
    chk("ifid_clr", int'(ifid_clr), e_ifc);
    chk("idex_clr", int'(idex_clr), e_idc);
    chk("rs_sel",   int'(fwd_rs_sel), srs);
    chk("rt_sel",   int'(fwd_rt_sel), srt);
    chk("stall",    int'(stall_cnt), m_stall);
    chk("flush",    int'(flush_cnt), m_flush);
    chk("stall_s",  int'(s_stall_cnt), m_stall_s);
    chk("flush_s",  int'(s_flush_cnt), m_flush_s);
    chk("pc_en_s",  int'(s_pc_en), e_pc);
    @(posedge clk);
    if (rst_n && !mem_busy) begin
      for (int k = D; k >= 2; k--) begin
        mv[k] = mv[k-1]; mw[k] = mw[k-1]; ml[k] = ml[k-1]; ma[k] = ma[k-1];
      end
      if (ex_redirect || luse != 0) begin
        mv[1] = 0; mw[1] = 0; ml[1] = 0; ma[1] = 0;
      end else begin
        mv[1] = int'(id_valid); mw[1] = int'(id_wr_en);
        ml[1] = int'(id_is_load); ma[1] = int'(id_wr_addr);
      end
      if (ex_redirect) begin
        if (m_flush < 65535) m_flush++;
        if (m_flush_s < 3) m_flush_s++;
      end else if (luse != 0) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall_s < 3) m_stall_s++;
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input int v, input int rs, input int rsu, input int rt, input int rtu,
                       input int we, input int wa, input int ld, input int redir, input int busy);
    id_valid = v[0]; id_rs = rs[4:0]; id_rs_used = rsu[0]; id_rt = rt[4:0];
    id_rt_used = rtu[0]; id_wr_en = we[0]; id_wr_addr = wa[4:0]; id_is_load = ld[0];
    ex_redirect = redir[0]; mem_busy = busy[0];
  endtask

  task automatic idle();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int s0, f0;

  initial begin
    model_clear();
    idle();
    @(negedge clk);
    // reset state, with noisy inputs that must not matter
    issue(1, 3, 1, 3, 1, 1, 3, 1, 1, 1);
    #1;
    chk("rst_pc_en", int'(pc_en), 1);
    chk("rst_ifid_clr", int'(ifid_clr), 0);
    chk("rst_stall", int'(stall_cnt), 0);
    cycle();
    rst_n = 1'b1; idle(); cycle();

    // EX then MEM forwarding of r3
    issue(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); cycle();
    issue(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); #1 chk("fwd_ex", int'(fwd_rs_sel), 1); cycle();
    issue(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); #1 chk("fwd_mem", int'(fwd_rs_sel), 2); cycle();
    idle(); cycle(); cycle(); cycle();

    // load-use: one stall, then forward from MEM
    s0 = m_stall;
    issue(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
    issue(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    #1 chk("lu_pc_en", int'(pc_en), 0); chk("lu_idex_clr", int'(idex_clr), 1);
    cycle();
    #1 chk("lu_fwd", int'(fwd_rt_sel), 2); chk("lu_pc_after", int'(pc_en), 1);
    chk("lu_cnt", int'(stall_cnt), s0 + 1);
    cycle();
    idle(); cycle(); cycle(); cycle();

    // r0 never matches; youngest of two r7 producers wins
    issue(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); cycle();
    issue(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    #1 chk("r0_sel", int'(fwd_rs_sel), 0); chk("r0_pc", int'(pc_en), 1);
    cycle();
    issue(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); cycle();
    issue(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); cycle();
    issue(1, 7, 1, 7, 1, 0, 0, 0, 0, 0);
    #1 chk("r7_rs", int'(fwd_rs_sel), 1); chk("r7_rt", int'(fwd_rt_sel), 1);
    cycle();
    idle(); cycle(); cycle(); cycle();

    // redirect dominates a load-use hazard
    s0 = m_stall; f0 = m_flush;
    issue(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
    issue(1, 0, 0, 5, 1, 0, 0, 0, 1, 0);
    #1 chk("rd_ifid_clr", int'(ifid_clr), 1); chk("rd_idex_clr", int'(idex_clr), 1);
    chk("rd_pc_en", int'(pc_en), 1);
    cycle();
    chk("rd_flush", int'(flush_cnt), f0 + 1); chk("rd_stall", int'(stall_cnt), s0);
    idle(); cycle(); cycle(); cycle();

    // freeze during a load-use stall: one stall counted
    s0 = m_stall;
    issue(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 0, 5, 1, 0, 0, 0, 0, 1);
      #1 chk("fz_pc_en", int'(pc_en), 0); chk("fz_idex_clr", int'(idex_clr), 0);
      chk("fz_sel", int'(fwd_rt_sel), 1);
      cycle();
    end
    issue(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); cycle();
    cycle();
    chk("fz_stall", int'(stall_cnt), s0 + 1);
    idle(); cycle(); cycle(); cycle();

    // saturation: clean reset, then 5 stalls
    rst_n = 1'b0; idle(); cycle(); rst_n = 1'b1; cycle();
    for (int i = 0; i < 5; i++) begin
      issue(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
      issue(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); cycle();
      cycle();
    end
    chk("sat_s", int'(s_stall_cnt), 3);
    chk("sat_wide", int'(stall_cnt), 5);

    // reset mid-freeze
    issue(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
    issue(1, 0, 0, 5, 1, 0, 0, 0, 0, 1); cycle();
    rst_n = 1'b0;
    #1 chk("rf_stall", int'(stall_cnt), 0); chk("rf_sel", int'(fwd_rt_sel), 0);
    chk("rf_pc_en", int'(pc_en), 1);
    cycle();
    rst_n = 1'b1; idle(); cycle();

    // randomized traffic over a small register space
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      issue(($urandom_range(0, 9) != 0) ? 1 : 0,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 7),
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            ($urandom_range(0, 4) == 0) ? 1 : 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the in-order five-stage pipeline (IF, ID, EX, MEM, WB). It tracks the destination of every instruction in flight past ID in an internal shadow pipeline. From that state it generates operand-forwarding selects, load-use stalls, a memory-busy freeze, and branch/jump flushes. It also keeps saturating stall and flush counters for performance analysis. It sits beside the datapath top level and drives the pipeline-register enables and clears.

## Interface
Parameters:
- REG_AW, 5, register address width
- FWD_DEPTH, 3, tracked stages after ID (1=EX, 2=MEM, 3=WB); legal range 2..6
- LOAD_LAT, 1, stages after EX before load data is forwardable; must be < FWD_DEPTH
- ZERO_REG, 1, when 1, register 0 never matches (no forward, no stall)
- CNT_W, 16, performance counter width

Ports:
- clk, in, 1, pipeline clock; all state updates on its rising edge
- rst_n, in, 1, asynchronous active-low reset
- id_valid, in, 1, ID holds a real instruction
- id_rs / id_rt, in, REG_AW, ID source register addresses
- id_rs_used / id_rt_used, in, 1, the source is actually read
- id_wr_en, in, 1, ID instruction writes the register file
- id_wr_addr, in, REG_AW, ID destination (already muxed rd/rt)
- id_is_load, in, 1, ID instruction is a memory load
- ex_redirect, in, 1, branch taken or jump resolved in EX
- mem_busy, in, 1, data memory not ready; whole pipeline freezes
- pc_en, out, 1, PC and IF/ID register may advance
- ifid_en, out, 1, IF/ID register may load
- ifid_clr, out, 1, IF/ID register loads a bubble
- idex_clr, out, 1, ID/EX register loads a bubble
- fwd_rs_sel / fwd_rt_sel, out, $clog2(FWD_DEPTH+1), 0 = register file, k = result of stage k
- stall_cnt / flush_cnt, out, CNT_W, saturating event counters

## Operation
- State: stage[1..FWD_DEPTH], each holding {valid, wr_en, is_load, addr}.
- Source match at stage k: valid & wr_en & addr==src & src_used & !(ZERO_REG & src==0).
- Forward select: the smallest matching k (youngest producer wins); 0 if no stage matches.
- Load-use hazard: for either source, the youngest match is a load with k <= LOAD_LAT, and id_valid=1.
- Priority, highest first:
  - mem_busy: freeze. pc_en=0, ifid_en=0, clears 0. All stage state holds. Counters hold. ex_redirect is ignored; EX must hold it stable.
  - ex_redirect: ifid_clr=1 and idex_clr=1, pc_en=1. stage[1] receives a bubble. flush_cnt increments. A redirect dominates a concurrent load-use hazard, and no stall is counted.
  - load-use hazard: pc_en=0, ifid_en=0, idex_clr=1. stage[1] receives a bubble. stall_cnt increments.
  - otherwise: advance. stage[1] receives {id_valid, id_wr_en, id_is_load, id_wr_addr}.
- In every non-frozen cycle, stage[k+1] <= stage[k]. The entry leaving stage[FWD_DEPTH] is dropped.
- Counters saturate at all-ones; they never wrap.
- Reset while rst_n=0:
  - all stage valid bits are 0 and counters are 0;
  - outputs are pc_en=1, ifid_en=1, clears 0, fwd selects 0, regardless of other inputs.
- Reset asserted mid-stall or mid-freeze discards all tracked state. The first cycle after release behaves as an empty pipeline.

## Timing
- fwd_*_sel, pc_en, ifid_en, ifid_clr and idex_clr are combinational from the current-cycle inputs and stage state. There is no registered latency, so the selects are valid in the same cycle ID reads the register file.
- Stage state and counters update at the rising clk edge following the decision.
- Load-use stall length: (LOAD_LAT - k + 1) cycles, where k is the producer's stage when the hazard is first seen. With the defaults, a load directly followed by its consumer stalls 1 cycle, then forwards with sel=2.
- A freeze extends any stall 1:1 and changes neither the selects nor the stall-count result.
- Consecutive redirects each flush and each count.

## Structure
- Package pipe_pkg:
  - stage entry typedef {valid, wr_en, is_load, addr};
  - FWD_RF = 0 constant;
  - function fwd_w(depth) = $clog2(depth+1).
- Sub-module hazard_fwd_match: a per-source priority encoder over all stages, returning the select and a load-hazard flag. It is instantiated twice (rs, rt).
- Top module: stage shift register, priority logic, counters. Target 150-250 lines.

## Test plan
- Add r3 in EX, then ID reads r3 as rs -> fwd_rs_sel=1, no stall. Next cycle, with r3 in MEM -> sel=2.
- lw r5 in EX, ID reads r5 as rt -> pc_en=0, idex_clr=1 for 1 cycle, stall_cnt 0->1. Next cycle fwd_rt_sel=2.
- Write to r0 in EX, ID reads r0 (ZERO_REG=1) -> sel=0, no stall. Two producers of r7 in EX and MEM -> sel=1.
- ex_redirect=1 during a load-use hazard -> ifid_clr=1, idex_clr=1, pc_en=1, flush_cnt+1, stall_cnt unchanged.
- mem_busy=1 for 3 cycles during a load-use stall -> pc_en=0, state held. After release, exactly 1 stall cycle is counted.
- CNT_W=2 with 5 stalls -> stall_cnt=3 (saturated). Assert rst_n mid-freeze -> counters 0, fwd selects 0 immediately.
